// File: rtl/fft_32_input_framer.sv
// fft_32_input_framer: frames a continuous complex sample stream into 32-point
// bursts for fft_32, double-buffered, with an enforced idle gap between bursts.
module fft_32_input_framer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_GAP  = 10
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Input_valid,
    input  logic [DATA_WIDTH-1:0] Input_i,
    input  logic [DATA_WIDTH-1:0] Input_q,
    output logic                  Output_valid,
    output logic [DATA_WIDTH-1:0] Output_i,
    output logic [DATA_WIDTH-1:0] Output_q,
    output logic [4:0]            Output_index,
    output logic                  Output_last,
    output logic                  Error_overflow
);

    localparam int unsigned AW    = 5;
    localparam int unsigned WORDW = 2 * DATA_WIDTH;
    localparam int unsigned GW    = $clog2(FRAME_GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_GAP
    } state_t;

    // Two banks of 32 {I,Q} words; bank select is the MSB of the address.
    logic [WORDW-1:0] mem_q [0:63];

    state_t                state_q,   state_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [AW-1:0]         wr_ptr_q,  wr_ptr_d;
    logic [1:0]            full_q,    full_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [AW-1:0]         rd_cnt_q,  rd_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_i_q,   out_i_d;
    logic [DATA_WIDTH-1:0] out_q_q,   out_q_d;
    logic [AW-1:0]         out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;
    logic                  ovf_q,     ovf_d;

    logic                  wr_en_c;
    logic [WORDW-1:0]      rd_word_c;

    assign wr_en_c   = Input_valid && !full_q[wr_bank_q];
    assign rd_word_c = mem_q[{rd_bank_q, rd_cnt_q}];

    // Sample storage; contents need no reset since full flags gate all reads.
    always_ff @(posedge Clk) begin
        if (wr_en_c) begin
            mem_q[{wr_bank_q, wr_ptr_q}] <= {Input_i, Input_q};
        end
    end

    // Write side, read FSM and registered output beat.
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_idx_d   = out_idx_q;
        ovf_d       = Input_valid && full_q[wr_bank_q];

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == AW'(31)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = S_READ;
                    rd_cnt_d = '0;
                end
            end
            S_READ: begin
                out_valid_d = 1'b1;
                out_i_d     = rd_word_c[WORDW-1:DATA_WIDTH];
                out_q_d     = rd_word_c[DATA_WIDTH-1:0];
                out_idx_d   = rd_cnt_q;
                out_last_d  = (rd_cnt_q == AW'(31));
                rd_cnt_d    = rd_cnt_q + AW'(1);
                if (rd_cnt_q == AW'(31)) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    state_d           = S_GAP;
                    gap_cnt_d         = '0;
                end
            end
            S_GAP: begin
                // First GAP cycle carries the last beat; then FRAME_GAP idle cycles.
                if (gap_cnt_q == GW'(FRAME_GAP)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Output_valid   = out_valid_q;
    assign Output_i       = out_i_q;
    assign Output_q       = out_q_q;
    assign Output_index   = out_idx_q;
    assign Output_last    = out_last_q;
    assign Error_overflow = ovf_q;

endmodule

// File: tb/tb_fft_32_input_framer.sv
// Scoreboard bench for fft_32_input_framer: stimulus pushes expected beats,
// a negedge monitor pops and compares every presented beat.
module tb_fft_32_input_framer;

    localparam int unsigned DW  = 16;
    localparam int unsigned GAP = 10;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Input_valid;
    logic [DW-1:0] Input_i;
    logic [DW-1:0] Input_q;
    logic          Output_valid;
    logic [DW-1:0] Output_i;
    logic [DW-1:0] Output_q;
    logic [4:0]    Output_index;
    logic          Output_last;
    logic          Error_overflow;

    fft_32_input_framer #(.DATA_WIDTH(DW), .FRAME_GAP(GAP)) dut (
        .Clk(Clk), .Rst(Rst),
        .Input_valid(Input_valid), .Input_i(Input_i), .Input_q(Input_q),
        .Output_valid(Output_valid), .Output_i(Output_i), .Output_q(Output_q),
        .Output_index(Output_index), .Output_last(Output_last),
        .Error_overflow(Error_overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic [4:0]    idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    lat_q[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    ovf_cnt = 0;
    int    prev_cyc = 0;
    int    last_cyc = 0;
    bit    have_last = 1'b0;
    beat_t got, e;

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every beat against the scoreboard, plus timing rules.
    always @(negedge Clk) begin
        if (Rst) begin
            if (Error_overflow) ovf_cnt++;
            if (Output_valid) begin
                got = {Output_i, Output_q, Output_index, Output_last};
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h required none (cycle %0d)", got, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(got), 64'(e));
                end
                if (Output_index != 5'd0) begin
                    check("contiguous", 64'(cyc), 64'(prev_cyc + 1));
                end else begin
                    if (have_last) begin
                        n_tests++;
                        if (cyc - last_cyc - 1 < int'(GAP)) begin
                            n_fail++;
                            $display("FAIL frame_gap: got %0d idle cycles required >= %0d", cyc - last_cyc - 1, GAP);
                        end
                    end
                    if (lat_q.size() > 0) check("index0_cycle", 64'(cyc), 64'(lat_q.pop_front()));
                end
                if (Output_last) begin
                    last_cyc  = cyc;
                    have_last = 1'b1;
                end
                prev_cyc = cyc;
            end
        end
    end

    task automatic tick_in(input logic v, input logic [DW-1:0] i, input logic [DW-1:0] q);
        @(posedge Clk);
        #1;
        Input_valid = v;
        Input_i     = i;
        Input_q     = q;
    endtask

    task automatic send(input logic [DW-1:0] i, input logic [DW-1:0] q, input bit push, input int k);
        tick_in(1'b1, i, q);
        if (push) exp_q.push_back({i, q, 5'(k), (k == 31)});
    endtask

    // One frame: ext=0 gives I=base+k, Q=-(base+k); ext=1 alternates extremes.
    task automatic send_frame(input int base, input bit ext, input bit push_lat, input int idle_max);
        logic [DW-1:0] i, q;
        for (int k = 0; k < 32; k++) begin
            if (idle_max > 0) begin
                repeat ($urandom_range(0, idle_max)) tick_in(1'b0, '0, '0);
            end
            if (ext) begin
                i = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
                q = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
            end else begin
                i = DW'(base + k);
                q = DW'(-(base + k));
            end
            send(i, q, 1'b1, k);
        end
        if (push_lat) lat_q.push_back(cyc + 3);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        Input_valid = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        have_last = 1'b0;
        ovf_cnt = 0;
    endtask

    task automatic drain(input string name, input int settle, input int exp_ovf);
        int t = 0;
        tick_in(1'b0, '0, '0);
        while ((exp_q.size() != 0 || Output_valid) && t < 3000) begin
            @(posedge Clk);
            t++;
        end
        repeat (settle) @(posedge Clk);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_overflow_count"}, 64'(ovf_cnt), 64'(exp_ovf));
        ovf_cnt = 0;
    endtask

    initial begin
        int c0;
        bit hit;
        logic [DW-1:0] v;
        Rst = 1'b0;
        Input_valid = 1'b0;
        Input_i = '0;
        Input_q = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_valid", 64'(Output_valid), 64'd0);
        check("rst_last", 64'(Output_last), 64'd0);
        check("rst_index", 64'(Output_index), 64'd0);
        check("rst_i", 64'(Output_i), 64'd0);
        check("rst_q", 64'(Output_q), 64'd0);
        check("rst_overflow", 64'(Error_overflow), 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // 1: single frame, latency C+3
        send_frame(0, 1'b0, 1'b1, 0);
        drain("t1", GAP + 5, 0);

        // 2: two frames back-to-back, second index 0 at +32+GAP+2
        send_frame(100, 1'b0, 1'b1, 0);
        c0 = lat_q[lat_q.size() - 1];
        send_frame(132, 1'b0, 1'b0, 0);
        lat_q.push_back(c0 + 32 + int'(GAP) + 2);
        drain("t2", GAP + 5, 0);
        check("t2_latency_queue_empty", 64'(lat_q.size()), 64'd0);

        // 3: 96 back-to-back; sample 64 hits the still-full bank and is dropped
        do_reset();
        for (int n = 0; n < 96; n++) begin
            v = DW'(n + 500);
            send(v, ~v, (n < 64), n % 32);
        end
        drain("t3", 80, 1);

        // 4: ~20% duty for 10 frames
        do_reset();
        for (int f = 0; f < 10; f++) send_frame(1000 + 32 * f, 1'b0, 1'b0, 7);
        drain("t4", GAP + 5, 0);

        // 5: reset at beat index 12, then a clean burst
        do_reset();
        send_frame(2000, 1'b0, 1'b0, 0);
        tick_in(1'b0, '0, '0);
        hit = 1'b0;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(posedge Clk);
            #2;
            if (Output_valid && Output_index == 5'd12) hit = 1'b1;
        end
        check("t5_saw_index12", 64'(hit), 64'd1);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        exp_q.delete();
        have_last = 1'b0;
        @(negedge Clk);
        check("t5_valid_after_reset", 64'(Output_valid), 64'd0);
        check("t5_index_after_reset", 64'(Output_index), 64'd0);
        repeat (5) @(posedge Clk);
        check("t5_no_beats_after_reset", 64'(Output_valid), 64'd0);
        send_frame(3000, 1'b0, 1'b1, 0);
        drain("t5", GAP + 5, 0);

        // 6: extreme values pass through unchanged
        send_frame(0, 1'b1, 1'b0, 0);
        drain("t6", GAP + 5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
